// File: rtl/rv32_pkg.sv
// Shared RV32IM encodings used by the writeback stage.
// Port summary: none (package only).
// Holds writeback-source selects and load funct3 codes.
package rv32_pkg;

  localparam int XLEN      = 32;
  localparam int INSTRET_W = 64;

  // Writeback source select
  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_IMM  = 2'b11;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Load alignment/extension: picks byte/half/word from the raw memory word and extends it.
// Ports: funct3, byte_off, word in -> data, misaligned, illegal out.
// Purely combinational, zero latency, no backpressure.
module load_extend
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte lane o lands in bits [7:0]; halves are chosen by o[1] only so a
  // misaligned half still produces a deterministic (but unused) value.
  assign shifted  = word >> {byte_off, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = byte_off[1] ? word[31:16] : word[15:0];

  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'h0, byte_sel};
      F3_LH: begin
        data       = {{16{half_sel[15]}}, half_sel};
        misaligned = byte_off[0];
      end
      F3_LHU: begin
        data       = {16'h0, half_sel};
        misaligned = byte_off[0];
      end
      F3_LW: begin
        data       = word;
        misaligned = (byte_off != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, load extension, writeback mux, WB->ID bypass and instret counter.
// Ports: clk/reset/stall/flush, mem_* stage inputs; regfile write port, bypass, load_fault, instret out.
// Latency 1 cycle MEM capture -> write strobe; stall holds the register and suppresses write/retire.
module writeback_stage
  import rv32_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 mem_valid,
  input  logic                 mem_reg_write,
  input  logic [4:0]           mem_rd_addr,
  input  logic [1:0]           mem_wb_sel,
  input  logic [2:0]           mem_funct3,
  input  logic [1:0]           mem_byte_off,
  input  logic [XLEN-1:0]      mem_alu_result,
  input  logic [XLEN-1:0]      mem_load_word,
  input  logic [XLEN-1:0]      mem_pc_plus4,
  input  logic [XLEN-1:0]      mem_imm,
  output logic                 write_enable,
  output logic [4:0]           write_reg_addr,
  output logic [XLEN-1:0]      reg_write_data,
  output logic                 wb_fwd_en,
  output logic [4:0]           wb_fwd_rd,
  output logic [XLEN-1:0]      wb_fwd_data,
  output logic                 load_fault,
  output logic [INSTRET_W-1:0] instret
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [4:0]      rd;
    logic [1:0]      wb_sel;
    logic [2:0]      funct3;
    logic [1:0]      byte_off;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] load_word;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] imm;
  } wb_stage_t;

  wb_stage_t            stage_q, stage_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  logic [31:0] load_data;
  logic        load_misaligned;
  logic        load_illegal;
  logic [XLEN-1:0] wb_data;
  logic        retire;

  load_extend u_load_extend (
    .funct3     (stage_q.funct3),
    .byte_off   (stage_q.byte_off),
    .word       (stage_q.load_word[31:0]),
    .data       (load_data),
    .misaligned (load_misaligned),
    .illegal    (load_illegal)
  );

  // Flush beats stall: a held instruction under flush is dropped unretired.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d.valid = 1'b0;
    end else if (!stall) begin
      stage_d.valid      = mem_valid;
      stage_d.reg_write  = mem_reg_write;
      stage_d.rd         = mem_rd_addr;
      stage_d.wb_sel     = mem_wb_sel;
      stage_d.funct3     = mem_funct3;
      stage_d.byte_off   = mem_byte_off;
      stage_d.alu_result = mem_alu_result;
      stage_d.load_word  = mem_load_word;
      stage_d.pc_plus4   = mem_pc_plus4;
      stage_d.imm        = mem_imm;
    end
  end

  // Retire whenever WB holds a real instruction and is not stalled; a
  // concurrent flush only kills the incoming instruction, not this one.
  assign retire    = stage_q.valid & ~stall;
  assign instret_d = instret_q + INSTRET_W'(retire);

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_q   <= '0;
      instret_q <= '0;
    end else begin
      stage_q   <= stage_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    wb_data = '0;
    case (stage_q.wb_sel)
      WB_SEL_ALU:  wb_data = stage_q.alu_result;
      WB_SEL_LOAD: wb_data = XLEN'(load_data);
      WB_SEL_PC4:  wb_data = stage_q.pc_plus4;
      WB_SEL_IMM:  wb_data = stage_q.imm;
      default:     wb_data = '0;
    endcase
  end

  assign load_fault = stage_q.valid & (stage_q.wb_sel == WB_SEL_LOAD)
                    & (load_misaligned | load_illegal);

  // Bypass stays visible while stalled so ID can still read the pending value.
  assign wb_fwd_en      = stage_q.valid & stage_q.reg_write & (stage_q.rd != 5'd0) & ~load_fault;
  assign wb_fwd_rd      = stage_q.rd;
  assign wb_fwd_data    = wb_data;
  assign write_enable   = wb_fwd_en & ~stall;
  assign write_reg_addr = stage_q.rd;
  assign reg_write_data = wb_data;
  assign instret        = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_reg_write;
  logic [4:0]  mem_rd_addr;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_byte_off;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_load_word;
  logic [31:0] mem_pc_plus4;
  logic [31:0] mem_imm;
  logic        write_enable;
  logic [4:0]  write_reg_addr;
  logic [31:0] reg_write_data;
  logic        wb_fwd_en;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic        load_fault;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;

  writeback_stage #(.XLEN(32), .INSTRET_W(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_rd_addr    (mem_rd_addr),
    .mem_wb_sel     (mem_wb_sel),
    .mem_funct3     (mem_funct3),
    .mem_byte_off   (mem_byte_off),
    .mem_alu_result (mem_alu_result),
    .mem_load_word  (mem_load_word),
    .mem_pc_plus4   (mem_pc_plus4),
    .mem_imm        (mem_imm),
    .write_enable   (write_enable),
    .write_reg_addr (write_reg_addr),
    .reg_write_data (reg_write_data),
    .wb_fwd_en      (wb_fwd_en),
    .wb_fwd_rd      (wb_fwd_rd),
    .wb_fwd_data    (wb_fwd_data),
    .load_fault     (load_fault),
    .instret        (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [1:0] off, input logic [31:0] alu,
                       input logic [31:0] word, input logic [31:0] pc4, input logic [31:0] imm);
    mem_valid      = v;
    mem_reg_write  = rw;
    mem_rd_addr    = rd;
    mem_wb_sel     = sel;
    mem_funct3     = f3;
    mem_byte_off   = off;
    mem_alu_result = alu;
    mem_load_word  = word;
    mem_pc_plus4   = pc4;
    mem_imm        = imm;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    bubble();
    step(); step();
    reset = 1'b1;
    step();
    checks++;
    if ({write_enable, write_reg_addr, reg_write_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data, load_fault} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b addr=%0d data=%h fwd=%b fwd_rd=%0d fwd_data=%h fault=%b, expected all 0",
               write_enable, write_reg_addr, reg_write_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data, load_fault);
    end
    checks++;
    if (instret !== 64'd0) begin
      errors++; $display("FAIL reset_instret: got %0d expected 0", instret);
    end
  endtask

  task automatic test_alu_write();
    drive(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 2'b00, 32'h0000_0007, 32'h0, 32'h0, 32'h0);
    step();
    checks++;
    if (write_enable !== 1'b1 || write_reg_addr !== 5'd3 || reg_write_data !== 32'h7) begin
      errors++;
      $display("FAIL alu_write: we=%b addr=%0d data=%h expected we=1 addr=3 data=00000007",
               write_enable, write_reg_addr, reg_write_data);
    end
    bubble();
    step();
    checks++;
    if (instret !== 64'd1) begin
      errors++; $display("FAIL alu_instret: got %0d expected 1", instret);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [4];
    logic [1:0]  offs [4];
    logic [31:0] exps [4];
    f3s[0] = 3'b000; offs[0] = 2'd3; exps[0] = 32'hFFFF_FF80; // LB
    f3s[1] = 3'b100; offs[1] = 2'd3; exps[1] = 32'h0000_0080; // LBU
    f3s[2] = 3'b001; offs[2] = 2'd2; exps[2] = 32'hFFFF_80FF; // LH
    f3s[3] = 3'b101; offs[3] = 2'd2; exps[3] = 32'h0000_80FF; // LHU
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 5'd10, 2'b01, f3s[i], offs[i], 32'h0, 32'h80FF_7F01, 32'h0, 32'h0);
      step();
      checks++;
      if (reg_write_data !== exps[i] || write_enable !== 1'b1 || load_fault !== 1'b0) begin
        errors++;
        $display("FAIL load_%0d: data=%h we=%b fault=%b expected data=%h we=1 fault=0",
                 i, reg_write_data, write_enable, load_fault, exps[i]);
      end
    end
    bubble();
    step();
    checks++;
    if (instret !== 64'd5) begin
      errors++; $display("FAIL load_instret: got %0d expected 5", instret);
    end
  endtask

  task automatic test_faults();
    logic [2:0] f3s  [3];
    logic [1:0] offs [3];
    f3s[0] = 3'b010; offs[0] = 2'd2; // LW misaligned
    f3s[1] = 3'b001; offs[1] = 2'd1; // LH misaligned
    f3s[2] = 3'b011; offs[2] = 2'd0; // illegal
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'd11, 2'b01, f3s[i], offs[i], 32'h0, 32'h1234_5678, 32'h0, 32'h0);
      step();
      checks++;
      if (load_fault !== 1'b1 || write_enable !== 1'b0 || wb_fwd_en !== 1'b0) begin
        errors++;
        $display("FAIL fault_%0d: fault=%b we=%b fwd=%b expected fault=1 we=0 fwd=0",
                 i, load_fault, write_enable, wb_fwd_en);
      end
    end
    bubble();
    step();
    checks++;
    if (instret !== 64'd8) begin
      errors++; $display("FAIL fault_instret: got %0d expected 8", instret);
    end
  endtask

  task automatic test_x0_and_jal();
    drive(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
    step();
    checks++;
    if (write_enable !== 1'b0 || wb_fwd_en !== 1'b0) begin
      errors++; $display("FAIL x0_write: we=%b fwd=%b expected 0 0", write_enable, wb_fwd_en);
    end
    drive(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0000_0104, 32'h0);
    step();
    checks++;
    if (write_enable !== 1'b1 || write_reg_addr !== 5'd1 || reg_write_data !== 32'h104) begin
      errors++;
      $display("FAIL jal_link: we=%b addr=%0d data=%h expected we=1 addr=1 data=00000104",
               write_enable, write_reg_addr, reg_write_data);
    end
    drive(1'b1, 1'b1, 5'd2, 2'b11, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 32'hABCD_E000);
    step();
    checks++;
    if (write_enable !== 1'b1 || reg_write_data !== 32'hABCD_E000) begin
      errors++; $display("FAIL lui_imm: we=%b data=%h expected we=1 data=abcde000", write_enable, reg_write_data);
    end
    bubble();
    step();
    checks++;
    if (instret !== 64'd11) begin
      errors++; $display("FAIL x0_instret: got %0d expected 11", instret);
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 2'b00, 32'h55, 32'h0, 32'h0, 32'h0);
    step();
    drive(1'b1, 1'b1, 5'd6, 2'b00, 3'b000, 2'b00, 32'h66, 32'h0, 32'h0, 32'h0);
    stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (write_enable !== 1'b0 || wb_fwd_en !== 1'b1 || wb_fwd_rd !== 5'd5 || wb_fwd_data !== 32'h55 || instret !== 64'd11) begin
        errors++;
        $display("FAIL stall_hold_%0d: we=%b fwd=%b fwd_rd=%0d fwd_data=%h instret=%0d expected 0 1 5 00000055 11",
                 i, write_enable, wb_fwd_en, wb_fwd_rd, wb_fwd_data, instret);
      end
      step();
    end
    stall = 1'b0;
    #1;
    checks++;
    if (write_enable !== 1'b1 || write_reg_addr !== 5'd5) begin
      errors++; $display("FAIL stall_release: we=%b addr=%0d expected we=1 addr=5", write_enable, write_reg_addr);
    end
    step();
    checks++;
    if (instret !== 64'd12 || write_reg_addr !== 5'd6 || write_enable !== 1'b1) begin
      errors++;
      $display("FAIL stall_retire: instret=%0d addr=%0d we=%b expected 12 6 1", instret, write_reg_addr, write_enable);
    end
    // Stall and flush together: held rd6 instruction is dropped.
    bubble();
    stall = 1'b1; flush = 1'b1;
    step();
    stall = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (write_enable !== 1'b0 || wb_fwd_en !== 1'b0 || instret !== 64'd12) begin
      errors++;
      $display("FAIL stall_flush: we=%b fwd=%b instret=%0d expected 0 0 12", write_enable, wb_fwd_en, instret);
    end
    step();
    checks++;
    if (instret !== 64'd12) begin
      errors++; $display("FAIL stall_flush_count: got %0d expected 12", instret);
    end
    // Flush alone: the WB instruction retires, the incoming one is killed.
    drive(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 2'b00, 32'h77, 32'h0, 32'h0, 32'h0);
    step();
    drive(1'b1, 1'b1, 5'd8, 2'b00, 3'b000, 2'b00, 32'h88, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bubble();
    #1;
    checks++;
    if (write_enable !== 1'b0 || wb_fwd_en !== 1'b0 || instret !== 64'd13) begin
      errors++;
      $display("FAIL flush_only: we=%b fwd=%b instret=%0d expected 0 0 13", write_enable, wb_fwd_en, instret);
    end
  endtask

  task automatic test_wrap_and_reset();
    step();
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    drive(1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 2'b00, 32'h99, 32'h0, 32'h0, 32'h0);
    step();
    bubble();
    step();
    checks++;
    if (instret !== 64'd0) begin
      errors++; $display("FAIL instret_wrap: got %h expected 0", instret);
    end
    drive(1'b1, 1'b1, 5'd4, 2'b00, 3'b000, 2'b00, 32'h44, 32'h0, 32'h0, 32'h0);
    step();
    stall = 1'b1;
    reset = 1'b0;
    bubble();
    step();
    checks++;
    if ({write_enable, write_reg_addr, reg_write_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data, load_fault} !== '0 || instret !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset: we=%b addr=%0d data=%h fwd=%b instret=%0d expected all 0",
               write_enable, write_reg_addr, reg_write_data, wb_fwd_en, instret);
    end
    reset = 1'b1;
    stall = 1'b0;
    step();
    checks++;
    if (write_enable !== 1'b0 || instret !== 64'd0) begin
      errors++; $display("FAIL post_reset: we=%b instret=%0d expected 0 0", write_enable, instret);
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_loads();
    test_faults();
    test_x0_and_jal();
    test_stall_flush();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
